// File: rtl/pc_seq_pkg.sv
// Shared encodings and constants for the program-counter sequencer.
// The FSM state values are visible on state_o, so their encodings must not change.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_DECODE  = 2'd1,
        S_RESOLVE = 2'd2,
        S_EXECUTE = 2'd3
    } state_t;

    localparam int PC_INCR      = 4;
    localparam int OFFSET_SHIFT = 2;

endpackage

// File: rtl/branch_target_calc.sv
// Branch target adder: sign-extends a word offset, scales it to bytes and adds it to PC+4.
// Purely combinational; the result wraps modulo 2^word_size.
module branch_target_calc
    import pc_seq_pkg::*;
#(
    parameter int word_size = 32,
    parameter int OFFSET_W  = 16
) (
    input  logic [word_size-1:0] i_base,
    input  logic [OFFSET_W-1:0]  i_offset,
    output logic [word_size-1:0] o_target
);

    logic [word_size-1:0] w_offset_sext;
    logic [word_size-1:0] w_offset_bytes;

    assign w_offset_sext  = {{(word_size-OFFSET_W){i_offset[OFFSET_W-1]}}, i_offset};
    assign w_offset_bytes = w_offset_sext << OFFSET_SHIFT;
    assign o_target       = i_base + w_offset_bytes;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner for the multicycle CPU: fetch handshake, branch resolve, PC update.
// Optional branch statistics counters are built when BRANCH_STATS_EN is defined.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   S_FETCH   | fetch_req high, waiting for fetch_ack; pc stable
//   S_DECODE  | one cycle; branch target computed and registered
//   S_RESOLVE | one cycle; branch_eval high, pc <= target or pc+4
//   S_EXECUTE | waiting for instr_done, then pc <= pc+4
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int                   word_size = 32,
    parameter logic [word_size-1:0] RESET_PC  = '0,
    parameter int                   OFFSET_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 fetch_req,
    input  logic                 fetch_ack,
    input  logic [OFFSET_W-1:0]  offset_in,
    input  logic                 is_branch,
    input  logic                 instr_done,
    output logic                 branch_eval,
    input  logic                 branch_taken,
    output logic [word_size-1:0] pc,
    output logic                 redirect,
    output logic [1:0]           state_o
`ifdef BRANCH_STATS_EN
   ,output logic [31:0]          br_count,
    output logic [31:0]          br_taken_count
`endif
);

    localparam logic [word_size-1:0] INCR = word_size'(PC_INCR);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_fetch_req;
    logic [word_size-1:0]  r_pc;
    logic [word_size-1:0]  r_pc_plus4;
    logic [word_size-1:0]  r_target;
    logic [OFFSET_W-1:0]   r_off_q;
    logic                  r_redirect;
    logic                  w_fetch_accept;
    logic                  w_branch_eval;
    logic [word_size-1:0]  w_target;

    // An ack only counts while our own request is up; stray or late acks are dropped.
    assign w_fetch_accept = (r_state == S_FETCH) && r_fetch_req && fetch_ack;

    branch_target_calc #(
        .word_size (word_size),
        .OFFSET_W  (OFFSET_W)
    ) u_target_calc (
        .i_base   (r_pc_plus4),
        .i_offset (r_off_q),
        .o_target (w_target)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_branch_eval = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (w_fetch_accept) begin
                    w_state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_branch) begin
                    w_state_nxt = S_RESOLVE;
                end else begin
                    w_state_nxt = S_EXECUTE;
                end
            end
            S_RESOLVE: begin
                w_branch_eval = 1'b1;
                w_state_nxt   = S_FETCH;
            end
            S_EXECUTE: begin
                if (instr_done) begin
                    w_state_nxt = S_FETCH;
                end
            end
            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase
    end

    // is_branch / branch_taken / instr_done are only looked at inside their own state,
    // so an X on them elsewhere never reaches a register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_FETCH;
            r_fetch_req <= 1'b0;
            r_pc        <= RESET_PC;
            r_pc_plus4  <= '0;
            r_target    <= '0;
            r_off_q     <= '0;
            r_redirect  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_fetch_req <= (w_state_nxt == S_FETCH);
            r_redirect  <= 1'b0;
            if (w_fetch_accept) begin
                r_pc_plus4 <= r_pc + INCR;
                r_off_q    <= offset_in;
            end
            if (r_state == S_DECODE) begin
                r_target <= w_target;
            end
            if (r_state == S_RESOLVE) begin
                if (branch_taken) begin
                    r_pc       <= r_target;
                    r_redirect <= 1'b1;
                end else begin
                    r_pc <= r_pc_plus4;
                end
            end
            if ((r_state == S_EXECUTE) && instr_done) begin
                r_pc <= r_pc_plus4;
            end
        end
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] r_br_count;
    logic [31:0] r_br_taken_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_br_count       <= '0;
            r_br_taken_count <= '0;
        end else if (r_state == S_RESOLVE) begin
            r_br_count <= r_br_count + 32'd1;
            if (branch_taken) begin
                r_br_taken_count <= r_br_taken_count + 32'd1;
            end
        end
    end

    assign br_count       = r_br_count;
    assign br_taken_count = r_br_taken_count;
`endif

    assign fetch_req   = r_fetch_req;
    assign branch_eval = w_branch_eval;
    assign pc          = r_pc;
    assign redirect    = r_redirect;
    assign state_o     = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; stats checks compile when BRANCH_STATS_EN is defined.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic        fetch_ack;
    logic [15:0] offset_in;
    logic        is_branch;
    logic        instr_done;
    logic        branch_eval;
    logic        branch_taken;
    logic [31:0] pc;
    logic        redirect;
    logic [1:0]  state_o;
`ifdef BRANCH_STATS_EN
    logic [31:0] br_count;
    logic [31:0] br_taken_count;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .fetch_req    (fetch_req),
        .fetch_ack    (fetch_ack),
        .offset_in    (offset_in),
        .is_branch    (is_branch),
        .instr_done   (instr_done),
        .branch_eval  (branch_eval),
        .branch_taken (branch_taken),
        .pc           (pc),
        .redirect     (redirect),
        .state_o      (state_o)
`ifdef BRANCH_STATS_EN
       ,.br_count       (br_count),
        .br_taken_count (br_taken_count)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for fetch_req, holds ack low for 'waits' cycles, then acks once.
    task automatic do_fetch(input logic [15:0] off, input int waits);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (fetch_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        n_total++;
        if (!ok) $display("FAIL fetch_req_timeout: fetch_req=%b after 20 cycles, want 1", fetch_req);
        else     n_pass++;
        repeat (waits) tick();
        fetch_ack = 1'b1;
        offset_in = off;
        tick();
        fetch_ack = 1'b0;
        offset_in = 'x;
    endtask

    // One branch instruction with zero-wait fetch; ends just after the RESOLVE exit edge.
    task automatic branch_instr(input logic [15:0] off, input logic taken, output int ev);
        do_fetch(off, 0);
        is_branch    = 1'b1;
        branch_taken = 'x;
        ev = 0;
        if (branch_eval === 1'b1) ev++;
        tick();
        is_branch    = 'x;
        branch_taken = taken;
        if (branch_eval === 1'b1) ev++;
        tick();
        branch_taken = 'x;
        if (branch_eval === 1'b1) ev++;
    endtask

    task automatic nonbranch_instr(input logic [15:0] off, input int waits, input int dly);
        do_fetch(off, waits);
        is_branch = 1'b0;
        tick();
        is_branch = 'x;
        repeat (dly) tick();
        instr_done = 1'b1;
        tick();
        instr_done = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_total++; if (pc !== 32'h0)       $display("FAIL reset_pc: got %h want 00000000", pc);        else n_pass++;
        n_total++; if (state_o !== 2'd0)   $display("FAIL reset_state: got %0d want 0", state_o);      else n_pass++;
        n_total++; if (fetch_req !== 1'b0) $display("FAIL reset_fetch_req: got %b want 0", fetch_req); else n_pass++;
        n_total++; if (branch_eval !== 1'b0) $display("FAIL reset_branch_eval: got %b want 0", branch_eval); else n_pass++;
        n_total++; if (redirect !== 1'b0)  $display("FAIL reset_redirect: got %b want 0", redirect);   else n_pass++;
        reset = 1'b0;
        tick();
        n_total++; if (fetch_req !== 1'b1) $display("FAIL post_reset_fetch_req: got %b want 1", fetch_req); else n_pass++;
    endtask

    task automatic test_nonbranch();
        tick();
        tick();
        n_total++; if (pc !== 32'h0 || fetch_req !== 1'b1)
            $display("FAIL fetch_wait: pc=%h req=%b want pc=00000000 req=1", pc, fetch_req); else n_pass++;
        fetch_ack = 1'b1;
        offset_in = 16'h1234;
        tick();
        fetch_ack = 1'b0;
        offset_in = 'x;
        n_total++; if (state_o !== 2'd1 || fetch_req !== 1'b0 || pc !== 32'h0)
            $display("FAIL ack_to_decode: state=%0d req=%b pc=%h want 1/0/00000000", state_o, fetch_req, pc); else n_pass++;
        is_branch = 1'b0;
        tick();
        is_branch = 'x;
        n_total++; if (state_o !== 2'd3 || branch_eval !== 1'b0)
            $display("FAIL decode_to_execute: state=%0d eval=%b want 3/0", state_o, branch_eval); else n_pass++;
        instr_done = 1'b1;
        tick();
        instr_done = 1'b0;
        n_total++; if (pc !== 32'h4) $display("FAIL nonbranch_pc: got %h want 00000004", pc); else n_pass++;
        n_total++; if (state_o !== 2'd0 || fetch_req !== 1'b1)
            $display("FAIL nonbranch_refetch: state=%0d req=%b want 0/1", state_o, fetch_req); else n_pass++;
    endtask

    task automatic test_branch_taken();
        int ev;
        branch_instr(16'h003E, 1'b1, ev);
        n_total++; if (ev !== 1) $display("FAIL taken_eval_cycles: got %0d want 1", ev); else n_pass++;
        n_total++; if (pc !== 32'h100) $display("FAIL taken_pc: got %h want 00000100", pc); else n_pass++;
        n_total++; if (redirect !== 1'b1) $display("FAIL taken_redirect: got %b want 1", redirect); else n_pass++;
        n_total++; if (fetch_req !== 1'b1) $display("FAIL taken_refetch: got %b want 1", fetch_req); else n_pass++;
        tick();
        n_total++; if (redirect !== 1'b0 || pc !== 32'h100)
            $display("FAIL redirect_pulse: redirect=%b pc=%h want 0/00000100", redirect, pc); else n_pass++;
    endtask

    task automatic test_branch_offsets();
        int ev;
        branch_instr(16'h0003, 1'b1, ev);
        n_total++; if (pc !== 32'h110 || redirect !== 1'b1)
            $display("FAIL fwd_offset: pc=%h redirect=%b want 00000110/1", pc, redirect); else n_pass++;
        branch_instr(16'hFFFB, 1'b1, ev);
        n_total++; if (pc !== 32'h100) $display("FAIL back_to_100: got %h want 00000100", pc); else n_pass++;
        branch_instr(16'hFFFE, 1'b1, ev);
        n_total++; if (pc !== 32'hFC || redirect !== 1'b1)
            $display("FAIL neg_offset_taken: pc=%h redirect=%b want 000000fc/1", pc, redirect); else n_pass++;
        branch_instr(16'h0000, 1'b1, ev);
        n_total++; if (pc !== 32'h100) $display("FAIL zero_offset: got %h want 00000100", pc); else n_pass++;
        branch_instr(16'hFFFE, 1'b0, ev);
        n_total++; if (pc !== 32'h104 || redirect !== 1'b0)
            $display("FAIL not_taken: pc=%h redirect=%b want 00000104/0", pc, redirect); else n_pass++;
        n_total++; if (ev !== 1) $display("FAIL not_taken_eval_cycles: got %0d want 1", ev); else n_pass++;
    endtask

    task automatic test_pc_wrap();
        int ev;
        branch_instr(16'hFFBD, 1'b1, ev);
        n_total++; if (pc !== 32'hFFFF_FFFC) $display("FAIL wrap_target: got %h want fffffffc", pc); else n_pass++;
        nonbranch_instr(16'h0000, 0, 0);
        n_total++; if (pc !== 32'h0) $display("FAIL wrap_plus4: got %h want 00000000", pc); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int reqs;
        int redirs;
        reqs   = 0;
        redirs = 0;
        fetch_ack    = 1'b1;
        offset_in    = 16'h0100;
        is_branch    = 1'b1;
        branch_taken = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (fetch_req === 1'b1) reqs++;
            if (redirect === 1'b1) redirs++;
            tick();
        end
        fetch_ack    = 1'b0;
        offset_in    = 'x;
        is_branch    = 'x;
        branch_taken = 'x;
        n_total++; if (reqs !== 3) $display("FAIL b2b_fetch_count: got %0d want 3", reqs); else n_pass++;
        n_total++; if (redirs !== 0) $display("FAIL b2b_redirects: got %0d want 0", redirs); else n_pass++;
        n_total++; if (pc !== 32'hC || state_o !== 2'd0)
            $display("FAIL b2b_pc: pc=%h state=%0d want 0000000c/0", pc, state_o); else n_pass++;
    endtask

    task automatic test_reset_mid_fetch();
        tick();
        reset = 1'b1;
        tick();
        n_total++; if (pc !== 32'h0 || state_o !== 2'd0 || fetch_req !== 1'b0)
            $display("FAIL rst_fetch: pc=%h state=%0d req=%b want 00000000/0/0", pc, state_o, fetch_req); else n_pass++;
        reset     = 1'b0;
        fetch_ack = 1'b1;
        offset_in = 16'h0005;
        tick();
        fetch_ack = 1'b0;
        offset_in = 'x;
        n_total++; if (state_o !== 2'd0 || fetch_req !== 1'b1)
            $display("FAIL late_ack_ignored: state=%0d req=%b want 0/1", state_o, fetch_req); else n_pass++;
        tick();
        n_total++; if (state_o !== 2'd0 || pc !== 32'h0)
            $display("FAIL late_ack_hold: state=%0d pc=%h want 0/00000000", state_o, pc); else n_pass++;
    endtask

    task automatic test_reset_mid_execute();
        nonbranch_instr(16'h0000, 1, 0);
        n_total++; if (pc !== 32'h4) $display("FAIL pre_exec_pc: got %h want 00000004", pc); else n_pass++;
        do_fetch(16'h0000, 0);
        is_branch = 1'b0;
        tick();
        is_branch = 'x;
        n_total++; if (state_o !== 2'd3) $display("FAIL in_execute: got %0d want 3", state_o); else n_pass++;
        instr_done = 1'b1;
        reset      = 1'b1;
        tick();
        n_total++; if (pc !== 32'h0 || state_o !== 2'd0 || fetch_req !== 1'b0)
            $display("FAIL rst_exec: pc=%h state=%0d req=%b want 00000000/0/0", pc, state_o, fetch_req); else n_pass++;
        reset = 1'b0;
        tick();
        instr_done = 1'b0;
        n_total++; if (pc !== 32'h0 || state_o !== 2'd0)
            $display("FAIL late_done_ignored: pc=%h state=%0d want 00000000/0", pc, state_o); else n_pass++;
    endtask

`ifdef BRANCH_STATS_EN
    task automatic test_branch_stats();
        int ev;
        n_total++; if (br_count !== 32'd3)
            $display("FAIL stats_before_reset: br_count=%0d want 3", br_count); else n_pass++;
        reset = 1'b1;
        tick();
        tick();
        n_total++; if (br_count !== 32'd0 || br_taken_count !== 32'd0)
            $display("FAIL stats_reset: br=%0d taken=%0d want 0/0", br_count, br_taken_count); else n_pass++;
        reset = 1'b0;
        tick();
        branch_instr(16'h0001, 1'b1, ev);
        branch_instr(16'h0002, 1'b0, ev);
        branch_instr(16'h0003, 1'b1, ev);
        n_total++; if (br_count !== 32'd3 || br_taken_count !== 32'd2)
            $display("FAIL stats_counts: br=%0d taken=%0d want 3/2", br_count, br_taken_count); else n_pass++;
    endtask
`endif

    initial begin
        reset        = 1'b1;
        fetch_ack    = 1'b0;
        offset_in    = '0;
        is_branch    = 1'b0;
        instr_done   = 1'b0;
        branch_taken = 1'b0;
        test_reset();
        test_nonbranch();
        test_branch_taken();
        test_branch_offsets();
        test_pc_wrap();
        test_back_to_back();
`ifdef BRANCH_STATS_EN
        // Before any further reset: the only branches since test_reset's counter
        // clear... counters run across all prior tests, so reset inside the task.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        begin
            int ev;
            branch_instr(16'h0001, 1'b1, ev);
            branch_instr(16'h0001, 1'b0, ev);
            branch_instr(16'h0001, 1'b1, ev);
        end
        test_branch_stats();
`endif
        test_reset_mid_fetch();
        test_reset_mid_execute();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time %0t exceeded limit", $time);
        $fatal(1, "simulation did not finish");
    end

endmodule
